// File: rtl/weights_addr_gen.sv
// weights_addr_gen: streams weights-ROM addresses 0..NB_WEIGHTS-1 once per pass,
// for a run-time number of passes, over an rts/rtr handshake with sow/eow framing.
// Optional feature macro: WEIGHTS_ADDR_GEN_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of cycles where an address was offered but not accepted.
module weights_addr_gen #(
  parameter int unsigned NB_WEIGHTS = 784,
  parameter int unsigned PASS_W     = 16,
  localparam int unsigned ADDR_W    = (NB_WEIGHTS > 1) ? $clog2(NB_WEIGHTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [PASS_W-1:0] nb_passes_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              rtr_i,
  output logic              rts_o,
  output logic              sow_o,
  output logic              eow_o,
  output logic [ADDR_W-1:0] address_o
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NB_WEIGHTS - 1);
  localparam logic              ONE_BEAT  = 1'(NB_WEIGHTS == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [PASS_W-1:0]  pass_cnt;
  logic [PASS_W-1:0]  last_pass;
  logic               transfer;

  assign transfer = rts_o & rtr_i;

  // Sweep sequencer: address/pass counters and all framing/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      last_pass <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rts_o     <= 1'b0;
      sow_o     <= 1'b0;
      eow_o     <= 1'b0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            pass_cnt  <= '0;
            last_pass <= PASS_W'(nb_passes_i - PASS_W'(1));
            if (nb_passes_i != '0) begin
              state     <= RUN;
              rts_o     <= 1'b1;
              address_o <= '0;
              sow_o     <= 1'b1;
              eow_o     <= ONE_BEAT;
            end else begin
              // Zero passes: go straight to the completion cycle, no transfers.
              state  <= FIN;
              done_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (transfer) begin
            if (eow_o) begin
              if (pass_cnt == last_pass) begin
                state     <= FIN;
                rts_o     <= 1'b0;
                sow_o     <= 1'b0;
                eow_o     <= 1'b0;
                address_o <= '0;
                done_o    <= 1'b1;
              end else begin
                // Wrap into the next pass with no bubble.
                pass_cnt  <= PASS_W'(pass_cnt + PASS_W'(1));
                address_o <= '0;
                sow_o     <= 1'b1;
                eow_o     <= ONE_BEAT;
              end
            end else begin
              address_o <= ADDR_W'(address_o + ADDR_W'(1));
              sow_o     <= 1'b0;
              eow_o     <= (ADDR_W'(address_o + ADDR_W'(1)) == LAST_ADDR);
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
          rts_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
  // Saturating back-pressure counter, restarted by each accepted sweep request.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      stall_cnt_o <= '0;
    end else if (rts_o && !rtr_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weights_addr_gen.sv
// Bench for weights_addr_gen: a small (NB_WEIGHTS=4) and a full-size (784) instance
// share rst/rtr/nb_passes, each with its own start. A queue-based model of the
// expected beat stream is checked every cycle; directed tests pin literal values.
module tb_weights_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0;
  logic        start784 = 1'b0;
  logic [15:0] nb_passes = '0;
  logic        rtr = 1'b1;

  logic        busy4, done4, rts4, sow4, eow4;
  logic [1:0]  addr4;
  logic        busy784, done784, rts784, sow784, eow784;
  logic [9:0]  addr784;
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
  logic [31:0] stall4, stall784;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  weights_addr_gen #(.NB_WEIGHTS(4), .PASS_W(16)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .nb_passes_i(nb_passes),
    .busy_o(busy4), .done_o(done4), .rtr_i(rtr), .rts_o(rts4),
    .sow_o(sow4), .eow_o(eow4), .address_o(addr4)
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
    , .stall_cnt_o(stall4)
`endif
  );

  weights_addr_gen #(.NB_WEIGHTS(784), .PASS_W(16)) dut784 (
    .clk(clk), .rst(rst), .start_i(start784), .nb_passes_i(nb_passes),
    .busy_o(busy784), .done_o(done784), .rtr_i(rtr), .rts_o(rts784),
    .sow_o(sow784), .eow_o(eow784), .address_o(addr784)
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
    , .stall_cnt_o(stall784)
`endif
  );

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Uniform views of both instances for the model loop.
  logic       busy_v[2], done_v[2], rts_v[2], sow_v[2], eow_v[2], start_v[2];
  logic [9:0] addr_v[2];
  int unsigned stall_v[2];
  always_comb begin
    busy_v[0] = busy4;   busy_v[1] = busy784;
    done_v[0] = done4;   done_v[1] = done784;
    rts_v[0]  = rts4;    rts_v[1]  = rts784;
    sow_v[0]  = sow4;    sow_v[1]  = sow784;
    eow_v[0]  = eow4;    eow_v[1]  = eow784;
    addr_v[0] = 10'(addr4);
    addr_v[1] = addr784;
    start_v[0] = start4; start_v[1] = start784;
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
    stall_v[0] = stall4; stall_v[1] = stall784;
`else
    stall_v[0] = 0;      stall_v[1] = 0;
`endif
  end

  // Model: a sweep is the list of beats (pass p, address a) in order; phase 0 idle,
  // 1 streaming, 2 completion cycle.
  typedef struct {
    int addr;
    bit sow;
    bit eow;
  } beat_t;

  beat_t       exp_q[2][$];
  int          ph[2]      = '{0, 0};
  int unsigned stall_m[2] = '{0, 0};
  int          nbw[2]     = '{4, 784};
  int          nbeats[2]  = '{0, 0};
  int          nsow[2]    = '{0, 0};
  int          neow[2]    = '{0, 0};
  int          ndone[2]   = '{0, 0};

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("busy[%0d]", k), int'(busy_v[k]), int'(ph[k] != 0));
      check_eq($sformatf("done[%0d]", k), int'(done_v[k]), int'(ph[k] == 2));
      check_eq($sformatf("rts[%0d]", k), int'(rts_v[k]), int'(ph[k] == 1));
      if (done_v[k]) ndone[k]++;
      if (ph[k] == 1 && rts_v[k] && exp_q[k].size() > 0) begin
        check_eq($sformatf("addr[%0d]", k), int'(addr_v[k]), exp_q[k][0].addr);
        check_eq($sformatf("sow[%0d]", k), int'(sow_v[k]), int'(exp_q[k][0].sow));
        check_eq($sformatf("eow[%0d]", k), int'(eow_v[k]), int'(exp_q[k][0].eow));
        check_eq($sformatf("addr_range[%0d]", k), int'(int'(addr_v[k]) <= nbw[k] - 1), 1);
      end
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
      check_eq($sformatf("stall[%0d]", k), int'(stall_v[k]), int'(stall_m[k]));
`endif
      if (rst) begin
        ph[k] = 0;
        exp_q[k].delete();
        stall_m[k] = 0;
      end else begin
        case (ph[k])
          0: if (start_v[k]) begin
            stall_m[k] = 0;
            for (int p = 0; p < int'(nb_passes); p++)
              for (int a = 0; a < nbw[k]; a++)
                exp_q[k].push_back('{addr: a, sow: (a == 0), eow: (a == nbw[k] - 1)});
            ph[k] = (nb_passes != 0) ? 1 : 2;
          end
          1: begin
            if (!rtr) begin
              if (stall_m[k] != 32'hFFFF_FFFF) stall_m[k]++;
            end else if (exp_q[k].size() > 0) begin
              nbeats[k]++;
              if (exp_q[k][0].sow) nsow[k]++;
              if (exp_q[k][0].eow) neow[k]++;
              void'(exp_q[k].pop_front());
              if (exp_q[k].size() == 0) ph[k] = 2;
            end
          end
          default: ph[k] = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input int bound, input string name);
    int c;
    c = 0;
    while (!done_v[k] && c < bound) begin
      step();
      c++;
    end
    check_eq({name, "_done_seen"}, int'(done_v[k]), 1);
  endtask

  int lit_addr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int lit_sow[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
  int lit_eow[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int cyc;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_rts", int'(rts4), 0);
    check_eq("reset_busy", int'(busy4), 0);
    check_eq("reset_addr", int'(addr4), 0);
    check_eq("reset_done", int'(done784), 0);

    // 1: two passes, rtr always high.
    nb_passes = 16'd2;
    rtr = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_rts", int'(rts4), 1);
      check_eq("t1_addr", int'(addr4), lit_addr[i]);
      check_eq("t1_sow", int'(sow4), lit_sow[i]);
      check_eq("t1_eow", int'(eow4), lit_eow[i]);
      step();
    end
    check_eq("t1_done", int'(done4), 1);
    check_eq("t1_rts_fin", int'(rts4), 0);
    step();
    check_eq("t1_done_clear", int'(done4), 0);
    check_eq("t1_busy_clear", int'(busy4), 0);

    // 2: rtr toggling 1010... from the first offered beat.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 40) begin
      rtr = (cyc % 2 == 0);
      step();
      cyc++;
    end
    check_eq("t2_done_seen", int'(done4), 1);
    check_eq("t2_cycles", cyc, 15);
`ifdef WEIGHTS_ADDR_GEN_STALL_CNT_EN
    check_eq("t2_stall_lit", int'(stall4), 7);
`endif
    rtr = 1'b1;
    step();

    // 3: zero passes.
    nb_passes = 16'd0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check_eq("t3_busy", int'(busy4), 1);
    check_eq("t3_done", int'(done4), 1);
    check_eq("t3_rts", int'(rts4), 0);
    step();
    check_eq("t3_busy_after", int'(busy4), 0);
    check_eq("t3_done_after", int'(done4), 0);

    // 4: starts while busy are ignored; a start right after done is accepted.
    nb_passes = 16'd2;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step(); step();
    nb_passes = 16'd1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    wait_done(0, 40, "t4a");
    start4 = 1'b1;
    step();
    check_eq("t4_fin_start_ignored", int'(busy4), 0);
    step();
    start4 = 1'b0;
    check_eq("t4_restart_rts", int'(rts4), 1);
    check_eq("t4_restart_addr", int'(addr4), 0);
    check_eq("t4_restart_sow", int'(sow4), 1);
    wait_done(0, 40, "t4b");
    step();

    // 5: reset at pass 1, address 2.
    nb_passes = 16'd2;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (6) step();
    check_eq("t5_pre_addr", int'(addr4), 2);
    check_eq("t5_pre_sow", int'(sow4), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_rts", int'(rts4), 0);
    check_eq("t5_addr", int'(addr4), 0);
    check_eq("t5_busy", int'(busy4), 0);
    check_eq("t5_done", int'(done4), 0);
    check_eq("t5_sow", int'(sow4), 0);
    check_eq("t5_eow", int'(eow4), 0);
    repeat (3) step();
    nb_passes = 16'd1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check_eq("t5_restart_addr", int'(addr4), 0);
    check_eq("t5_restart_sow", int'(sow4), 1);
    wait_done(0, 40, "t5");
    step();

    // 6: full-size instance, three passes, random back-pressure.
    nbeats[1] = 0; nsow[1] = 0; neow[1] = 0;
    nb_passes = 16'd3;
    start784 = 1'b1;
    step();
    start784 = 1'b0;
    cyc = 0;
    while (!done784 && cyc < 20000) begin
      rtr = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    check_eq("t6_done_seen", int'(done784), 1);
    rtr = 1'b1;
    step();
    check_eq("t6_beats", nbeats[1], 2352);
    check_eq("t6_sow_count", nsow[1], 3);
    check_eq("t6_eow_count", neow[1], 3);
    check_eq("t6_queue_empty", exp_q[1].size(), 0);
    check_eq("t4_queue_empty", exp_q[0].size(), 0);
    check_eq("small_done_count", ndone[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
